// File: rtl/pattern_recorder.sv
// Live tap recorder: quantizes debounced taps to the shared step tick and writes one 16-step pass
// into the selected voice's slice of a 64-bit pattern bank.
module pattern_recorder #(
  parameter int STEPS           = 16,
  parameter int VOICES          = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      step_tick,
  input  logic                      tap,
  input  logic [VOICES-1:0]         voice_sel,
  input  logic                      arm,
  input  logic                      clear,
  output logic [$clog2(STEPS)-1:0]  step_idx,
  output logic                      rec_active,
  output logic                      armed,
  output logic                      done,
  output logic                      tap_clean,
  output logic [STEPS*VOICES-1:0]   pattern_out,
  output logic [STEPS-1:0]          sel_pattern
);

  localparam int SW = $clog2(STEPS);
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int BW = $clog2(STEPS * VOICES);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORD} state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync2_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      clean_q, clean_d, clean_prev_q;
  logic [SW-1:0]             step_q, step_d;
  logic                      pend_q, pend_d;
  logic [VW-1:0]             rec_voice_q, rec_voice_d;
  logic [STEPS*VOICES-1:0]   bank_q, bank_d;
  logic                      done_q, done_d;
  logic                      armed_q, rec_q;

  logic                      tap_event;
  logic                      sel_any;
  logic [VW-1:0]             sel_voice;
  logic [BW-1:0]             sel_base, wr_idx;

  // Lowest set bit of the one-hot select wins if several bits are set.
  always_comb begin
    sel_voice = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (voice_sel[i]) sel_voice = VW'(i);
    end
  end

  assign sel_any   = |voice_sel;
  assign sel_base  = BW'(sel_voice) * BW'(STEPS);
  assign wr_idx    = BW'(rec_voice_q) * BW'(STEPS) + BW'(step_q);
  assign tap_event = clean_q & ~clean_prev_q;

  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) clean_d = ~clean_q;
      else                                    cnt_d   = cnt_q + 1'b1;
    end
  end

  always_comb begin
    step_d = step_q;
    if (step_tick) step_d = (step_q == LAST) ? '0 : step_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rec_voice_d = rec_voice_q;
    bank_d      = bank_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          if (sel_any) bank_d[sel_base +: STEPS] = '0;
        end else if (arm && sel_any) begin
          state_d     = S_ARMED;
          rec_voice_d = sel_voice;
        end
      end
      S_ARMED: begin
        pend_d = 1'b0;
        if (step_tick && step_q == LAST) state_d = S_RECORD;
      end
      S_RECORD: begin
        // A tap landing on the closing tick still belongs to the step being written.
        if (step_tick) begin
          bank_d[wr_idx] = pend_q | tap_event;
          pend_d         = 1'b0;
          if (step_q == LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tap_event) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      step_q       <= '0;
      pend_q       <= 1'b0;
      rec_voice_q  <= '0;
      bank_q       <= '0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      rec_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= tap;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      step_q       <= step_d;
      pend_q       <= pend_d;
      rec_voice_q  <= rec_voice_d;
      bank_q       <= bank_d;
      done_q       <= done_d;
      armed_q      <= (state_d == S_ARMED);
      rec_q        <= (state_d == S_RECORD);
    end
  end

  assign step_idx    = step_q;
  assign rec_active  = rec_q;
  assign armed       = armed_q;
  assign done        = done_q;
  assign tap_clean   = clean_q;
  assign pattern_out = bank_q;
  assign sel_pattern = sel_any ? bank_q[sel_base +: STEPS] : '0;

endmodule

// File: tb/tb_pattern_recorder.sv
// Directed bench for pattern_recorder: short debounce, step tick every 32 cycles.
module tb_pattern_recorder;

  logic        clk = 1'b0;
  logic        reset, step_tick, tap, arm, clear;
  logic [3:0]  voice_sel;
  logic [3:0]  step_idx;
  logic        rec_active, armed, done, tap_clean;
  logic [63:0] pattern_out;
  logic [15:0] sel_pattern;

  int tests  = 0;
  int failed = 0;
  int phase  = 0;
  int tb_step = 0;
  int rises  = 0;
  int rise_base;
  logic tc_prev = 1'b0;

  pattern_recorder #(.STEPS(16), .VOICES(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .reset(reset), .step_tick(step_tick), .tap(tap),
    .voice_sel(voice_sel), .arm(arm), .clear(clear), .step_idx(step_idx),
    .rec_active(rec_active), .armed(armed), .done(done), .tap_clean(tap_clean),
    .pattern_out(pattern_out), .sel_pattern(sel_pattern)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tap_clean && !tc_prev) rises <= rises + 1;
    tc_prev <= tap_clean;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; tick is driven during the phase-31 cycle of every 32.
  task automatic step1();
    @(posedge clk); #1;
    if (step_tick) tb_step = (tb_step + 1) % 16;
    phase = (phase == 31) ? 0 : phase + 1;
    step_tick = (phase == 31);
  endtask

  task automatic wait_for(input int s, input int q);
    int n;
    n = 0;
    while (!(tb_step == s && phase == q) && n < 2000) begin
      step1();
      n++;
    end
    if (n >= 2000) check("wait_timeout", 64'(tb_step * 32 + phase), 64'(s * 32 + q));
  endtask

  task automatic wait_wrap();
    step1();
    wait_for(0, 0);
  endtask

  task automatic press();
    tap = 1'b1;
    repeat (8) step1();
    tap = 1'b0;
    repeat (8) step1();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step1();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step_tick = 1'b0; tap = 1'b0; arm = 1'b0; clear = 1'b0;
    voice_sel = 4'b0000;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_pattern", pattern_out, 64'h0);
    check("rst_step", 64'(step_idx), 64'd0);
    check("rst_flags", 64'({rec_active, armed, done, tap_clean}), 64'd0);
    reset = 1'b0; phase = 0; tb_step = 0;

    // Voice 1, arm at step 7, taps at steps 0, 4 (twice), 15; a tap while armed is dropped.
    voice_sel = 4'b0010;
    wait_for(7, 5);
    check("step_at_7", 64'(step_idx), 64'd7);
    pulse_arm();
    check("armed_after_arm", 64'(armed), 64'd1);
    wait_for(10, 2); press();
    wait_for(15, 20);
    check("armed_before_wrap", 64'({armed, rec_active}), 64'b10);
    wait_for(0, 2);
    check("recording", 64'({armed, rec_active}), 64'b01);
    press();
    wait_for(4, 2); press(); press();
    wait_for(15, 2); press();
    wait_for(0, 0);
    check("a_done", 64'(done), 64'd1);
    check("a_pattern", pattern_out, 64'h0000_0000_8011_0000);
    check("a_idle", 64'({armed, rec_active}), 64'd0);
    check("a_sel", 64'(sel_pattern), 64'h8011);
    step1();
    check("a_done_once", 64'(done), 64'd0);

    // Bounce on voice 3 during step 2, then a clean hold in step 3.
    voice_sel = 4'b1000;
    pulse_arm();
    wait_wrap();
    rise_base = rises;
    wait_for(2, 0);
    repeat (10) begin
      tap = 1'b1; step1(); step1();
      tap = 1'b0; step1(); step1();
    end
    tap = 1'b1;
    repeat (5) step1();
    check("b_clean_early", 64'(tap_clean), 64'd0);
    step1();
    check("b_clean_rise", 64'(tap_clean), 64'd1);
    repeat (14) step1();
    tap = 1'b0;
    wait_for(0, 0);
    check("b_single_rise", 64'(rises - rise_base), 64'd1);
    check("b_pattern", pattern_out, 64'h0008_0000_8011_0000);
    step1();

    // Re-record voice 1 with no taps: replace semantics.
    voice_sel = 4'b0010;
    pulse_arm();
    wait_wrap();
    wait_wrap();
    check("c_done", 64'(done), 64'd1);
    check("c_pattern", pattern_out, 64'h0008_0000_0000_0000);
    step1();

    // Tap edge coincides with the tick that ends step 3.
    voice_sel = 4'b0001;
    pulse_arm();
    wait_wrap();
    wait_for(3, 25); press();
    wait_for(0, 0);
    check("d_pattern", pattern_out, 64'h0008_0000_0000_0008);
    step1();

    // Fill voice 0, then arm+clear together.
    pulse_arm();
    wait_wrap();
    for (int s = 0; s < 16; s++) begin
      wait_for(s, 2); press();
    end
    wait_for(0, 0);
    check("e_fill", 64'(sel_pattern), 64'hFFFF);
    step1();
    arm = 1'b1; clear = 1'b1;
    step1();
    arm = 1'b0; clear = 1'b0;
    check("e_cleared", pattern_out, 64'h0008_0000_0000_0000);
    check("e_stay_idle", 64'({armed, rec_active}), 64'd0);

    // arm with no voice is ignored; 4'b1100 targets voice 2 even if select moves.
    voice_sel = 4'b0000;
    pulse_arm();
    check("f_no_voice", 64'(armed), 64'd0);
    voice_sel = 4'b1100;
    pulse_arm();
    check("f_armed", 64'(armed), 64'd1);
    voice_sel = 4'b0001;
    wait_wrap();
    wait_for(5, 2); press();
    wait_for(0, 0);
    check("f_pattern", pattern_out, 64'h0008_0020_0000_0000);
    voice_sel = 4'b1100; #1;
    check("f_sel_v2", 64'(sel_pattern), 64'h0020);
    voice_sel = 4'b0000; #1;
    check("f_sel_none", 64'(sel_pattern), 64'h0);
    step1();

    // Reset in the middle of a pass.
    voice_sel = 4'b0001;
    pulse_arm();
    wait_wrap();
    for (int s = 0; s < 5; s++) begin
      wait_for(s, 2); press();
    end
    wait_for(5, 10);
    check("g_recording", 64'(rec_active), 64'd1);
    reset = 1'b1;
    step1();
    reset = 1'b0;
    check("g_pattern", pattern_out, 64'h0);
    check("g_step", 64'(step_idx), 64'd0);
    check("g_flags", 64'({rec_active, armed, done}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
